// File: rtl/cpu8_pkg.sv
// Shared opcodes, FSM state encoding and PC source selects for the 8-bit CPU control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu8_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic PC_SRC_INC = 1'b0;  // PC+1
  localparam logic PC_SRC_JMP = 1'b1;  // PC+1+sext(imm)

  // Codes 5-7 are unused and recovered to FETCH by the controller.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

endpackage

// File: rtl/cpu8_tick_gen.sv
// FSM step pulse: clk50 divider (default) or debounced-by-sync step button edge (CPU8_SINGLE_STEP_EN).
// Latency: tick high one clk50 per TICK_DIV cycles; button edge appears 2 clk50 after the press is sampled.
// Backpressure: none; the divider free-runs and the consumer decides whether to use each tick.
module cpu8_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic i_clk50,
  input  logic i_reset,
  input  logic i_step,
  output logic o_tick
);

`ifdef CPU8_SINGLE_STEP_EN
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two-flop synchronizer followed by a one-flop history for rising-edge detection.
  always_ff @(posedge i_clk50) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_step;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_tick = r_sync2 & ~r_prev;
`else
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_unused_step;

  assign w_unused_step = i_step;
  assign o_tick        = (r_cnt == LAST);

  // Divider counts 0..TICK_DIV-1 and wraps; the terminal count is the tick.
  always_ff @(posedge i_clk50) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: rtl/cpu8_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 8-bit CPU; optional CPU8_SINGLE_STEP_EN steps on button presses.
// Latency: one state per tick; add 4, lw 5, sw 4, j 3 ticks; strobes are 1 clk50 wide on the advancing tick.
// Backpressure: run=0 parks the FSM in FETCH with no strobes; other states always advance on a tick.
module cpu8_multicycle_ctrl
  import cpu8_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic       run,
  input  logic       step,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       alu_src,
  output logic       mem_re,
  output logic       mem_we,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       reg_dst,
  output logic [2:0] state,
  output logic [7:0] instr_count
);

  state_t     r_state;
  logic [1:0] r_op;
  logic [7:0] r_instr_count;

  state_t w_state_nxt;
  logic   w_tick;
  logic   w_adv;
  logic   w_op_ld;
  logic   w_retire;
  logic   w_ir_we, w_pc_we, w_pc_src, w_alu_src, w_mem_re;
  logic   w_mem_we, w_mem_to_reg, w_reg_we, w_reg_dst;

  cpu8_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk50 (clk50),
    .i_reset (reset),
    .i_step  (step),
    .o_tick  (w_tick)
  );

  // FETCH waits for run; every other state moves on the next tick.
  assign w_adv = w_tick && ((r_state != ST_FETCH) || run);

  // Next-state and control decode; levels follow the state, strobes only on the advancing tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_ld      = 1'b0;
    w_retire     = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = PC_SRC_INC;
    w_alu_src    = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_dst    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (w_adv) begin
          w_ir_we     = 1'b1;
          w_pc_we     = 1'b1;
          w_op_ld     = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_adv) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_alu_src = (r_op == OP_LW) || (r_op == OP_SW);
        if (r_op == OP_J) w_pc_src = PC_SRC_JMP;
        if (w_adv) begin
          case (r_op)
            OP_ADD:       w_state_nxt = ST_WB;
            OP_LW, OP_SW: w_state_nxt = ST_MEM;
            default: begin
              w_pc_we     = 1'b1;
              w_retire    = 1'b1;
              w_state_nxt = ST_FETCH;
            end
          endcase
        end
      end
      ST_MEM: begin
        w_mem_re = (r_op == OP_LW);
        if (w_adv) begin
          if (r_op == OP_LW) begin
            w_state_nxt = ST_WB;
          end else begin
            w_mem_we    = 1'b1;
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        w_mem_to_reg = (r_op == OP_LW);
        w_reg_dst    = (r_op == OP_ADD);
        if (w_adv) begin
          w_reg_we    = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk50) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_op          <= OP_ADD;
      r_instr_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_op_ld)  r_op          <= instruction[7:6];
      if (w_retire) r_instr_count <= r_instr_count + 8'd1;
    end
  end

  // Reset masks every control so nothing fires while an instruction is being aborted.
  assign ir_we       = w_ir_we      & ~reset;
  assign pc_we       = w_pc_we      & ~reset;
  assign pc_src      = w_pc_src     & ~reset;
  assign alu_src     = w_alu_src    & ~reset;
  assign mem_re      = w_mem_re     & ~reset;
  assign mem_we      = w_mem_we     & ~reset;
  assign mem_to_reg  = w_mem_to_reg & ~reset;
  assign reg_we      = w_reg_we     & ~reset;
  assign reg_dst     = w_reg_dst    & ~reset;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu8_multicycle_ctrl.sv
// Scoreboarded bench for cpu8_multicycle_ctrl with TICK_DIV=4.
// Expected per-step output records are queued when instructions are issued and checked every clk50.
// CPU8_SINGLE_STEP_EN builds run a short button-step sequence instead.
module tb_cpu8_multicycle_ctrl;
  localparam int TD = 4;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       ir_we, pc_we, pc_src, alu_src, mem_re, mem_we, mem_to_reg, reg_we, reg_dst;
  logic [2:0] state;
  logic [7:0] instr_count;

  always #10 clk50 = ~clk50;

  cpu8_multicycle_ctrl #(.TICK_DIV(TD)) dut (
    .clk50(clk50), .reset(reset), .instruction(instruction), .run(run), .step(step),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src(alu_src), .mem_re(mem_re),
    .mem_we(mem_we), .mem_to_reg(mem_to_reg), .reg_we(reg_we), .reg_dst(reg_dst),
    .state(state), .instr_count(instr_count)
  );

  // vec = {state[2:0], count[7:0], pc_src, alu_src, mem_re, mem_to_reg, reg_dst, ir_we, pc_we, mem_we, reg_we}
  typedef struct packed {
    logic [7:0]  instr;
    logic [19:0] vec;
  } rec_t;

  rec_t       q[$];
  int         errs = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = 8'd0;
  int         m_cnt = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk(input logic [2:0] st, input logic [7:0] cnt,
                                      input logic [4:0] lv, input logic [3:0] stb);
    return {st, cnt, lv, stb};
  endfunction

  // Queue the expected step records of one instruction.
  task automatic push_instr(input logic [7:0] ins);
    logic [1:0] op;
    op = ins[7:6];
    q.push_back({ins, mk(3'd0, exp_cnt, 5'b00000, 4'b1100)});
    q.push_back({ins, mk(3'd1, exp_cnt, 5'b00000, 4'b0000)});
    case (op)
      2'b00: begin
        q.push_back({ins, mk(3'd2, exp_cnt, 5'b00000, 4'b0000)});
        q.push_back({ins, mk(3'd4, exp_cnt, 5'b00001, 4'b0001)});
      end
      2'b01: begin
        q.push_back({ins, mk(3'd2, exp_cnt, 5'b01000, 4'b0000)});
        q.push_back({ins, mk(3'd3, exp_cnt, 5'b00100, 4'b0000)});
        q.push_back({ins, mk(3'd4, exp_cnt, 5'b00010, 4'b0001)});
      end
      2'b10: begin
        q.push_back({ins, mk(3'd2, exp_cnt, 5'b01000, 4'b0000)});
        q.push_back({ins, mk(3'd3, exp_cnt, 5'b00000, 4'b0010)});
      end
      default: begin
        q.push_back({ins, mk(3'd2, exp_cnt, 5'b10000, 4'b0100)});
      end
    endcase
    exp_cnt = exp_cnt + 8'd1;
  endtask

  // Reference tick counter, independent of the DUT.
  always @(posedge clk50) begin
    if (reset) m_cnt <= 0;
    else       m_cnt <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
  end

  // Monitor: compare every cycle, pop a record on each tick, present the current instruction.
  initial begin
    logic [19:0] obs;
    logic [19:0] ex;
    bit          tk;
    forever begin
      @(negedge clk50);
      if (mon_en && !reset) begin
        obs = {state, instr_count, pc_src, alu_src, mem_re, mem_to_reg, reg_dst,
               ir_we, pc_we, mem_we, reg_we};
        tk  = (m_cnt == TD - 1);
        if (q.size() != 0) ex = q[0].vec;
        else               ex = mk(3'd0, exp_cnt, 5'b00000, 4'b0000);
        if (!tk) ex[3:0] = 4'b0000;
        chk("cycle", {12'd0, obs}, {12'd0, ex});
        if (tk && q.size() != 0) void'(q.pop_front());
        instruction = (q.size() != 0) ? q[0].instr : 8'h00;
      end
    end
  end

  task automatic run_prog(input logic [7:0] ins, input int n);
    bit done;
    @(posedge clk50); #1;
    for (int i = 0; i < n; i++) push_instr(ins);
    run  = 1'b1;
    done = 1'b0;
    for (int c = 0; c < n * 40 + 40; c++) begin
      @(posedge clk50); #1;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("drain_timeout", 32'd1, 32'd0);
      q.delete();
    end
    run = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    repeat (2) @(posedge clk50);
    #1 reset = 1'b0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_count", {24'd0, instr_count}, 32'd0);
    chk("rst_strobes", {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
`ifdef CPU8_SINGLE_STEP_EN
    run = 1'b1;
    instruction = 8'h18;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (5) @(posedge clk50);
      #1 step = 1'b0;
      repeat (10) @(posedge clk50);
      #1;
      case (p)
        0: chk("step_state1", {29'd0, state}, 32'd1);
        1: chk("step_state2", {29'd0, state}, 32'd2);
        default: chk("step_state3", {29'd0, state}, 32'd4);
      endcase
    end
    repeat (30) @(posedge clk50);
    #1 chk("step_hold", {29'd0, state}, 32'd4);
`else
    mon_en = 1'b1;
    run_prog(8'h18, 1);
    chk("add_count", {24'd0, instr_count}, 32'd1);
    run_prog(8'h49, 1);
    run_prog(8'hA9, 1);
    run_prog(8'hC1, 2);
    chk("mix_count", {24'd0, instr_count}, 32'd5);
    for (int i = 0; i < 8; i++) run_prog(8'($urandom_range(0, 255)), 1);

    // Reset on the MEM tick of a lw aborts it.
    @(posedge clk50); #1;
    push_instr(8'h49);
    run = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk50); #1;
      if (state == 3'd3 && m_cnt == TD - 1) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_mem_tick", {31'd0, hit}, 32'd1);
    mon_en = 1'b0;
    q.delete();
    reset = 1'b1;
    #1 chk("abort_strobes", {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
    @(posedge clk50); #1;
    run = 1'b0;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_count", {24'd0, instr_count}, 32'd0);
    reset   = 1'b0;
    exp_cnt = 8'd0;
    mon_en  = 1'b1;

    // run=0 parks in FETCH; the monitor checks every idle cycle.
    repeat (40) @(posedge clk50);
    #1 chk("idle_state", {29'd0, state}, 32'd0);

    run_prog(8'h18, 256);
    chk("wrap_count", {24'd0, instr_count}, 32'd0);
    repeat (4) @(posedge clk50);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
